// File: rtl/dco_cbank_pkg.sv
// Shared types and default geometry for the DCO capacitor-bank controller.
package dco_cbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SLEW   = 2'd1,
    SETTLE = 2'd2
  } state_e;

  localparam int DEF_ROW_W = 4;
  localparam int DEF_COL_W = 4;
  localparam int CODE_W    = DEF_ROW_W + DEF_COL_W;
  localparam int NROWS     = 1 << DEF_ROW_W;
  localparam int NCOLS     = 1 << DEF_COL_W;
  localparam int MAX_CODE  = (1 << CODE_W) - 1;

endpackage

// File: rtl/dco_cbank_ctrl_if.sv
// Target-word handshake between the ADPLL loop filter and the bank controller.
interface dco_cbank_ctrl_if #(
  parameter int WORD_W = 8
) ();

  logic [WORD_W-1:0] word_i;
  logic              word_vld_i;
  logic              word_rdy_o;

  modport master (output word_i, output word_vld_i, input word_rdy_o);
  modport slave  (input word_i, input word_vld_i, output word_rdy_o);

endinterface

// File: rtl/dco_cbank_decode.sv
// Combinational code -> row-all / one-hot row / serpentine column decoder.
module dco_cbank_decode #(
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input  logic [ROW_W+COL_W-1:0] i_code,
  output logic [(1<<ROW_W)-1:0]  o_r_all_n,
  output logic [(1<<ROW_W)-1:0]  o_row,
  output logic [(1<<COL_W)-1:0]  o_col
);

  localparam int NR = 1 << ROW_W;
  localparam int NC = 1 << COL_W;

  logic [ROW_W-1:0] w_rsel;
  logic [COL_W-1:0] w_csel;

  assign w_rsel = i_code[ROW_W+COL_W-1:COL_W];
  assign w_csel = i_code[COL_W-1:0];

  // Rows below rsel are full; odd rows fill their columns from the top end.
  always_comb begin
    o_r_all_n = '1;
    o_row     = '0;
    o_col     = '0;
    for (int i = 0; i < NR; i++) begin
      o_r_all_n[i] = (ROW_W'(i) < w_rsel) ? 1'b0 : 1'b1;
      o_row[i]     = (ROW_W'(i) == w_rsel) ? 1'b1 : 1'b0;
    end
    for (int j = 0; j < NC; j++) begin
      if (w_rsel[0]) begin
        o_col[j] = (((COL_W+1)'(j) + {1'b0, w_csel}) >= (COL_W+1)'(NC)) ? 1'b1 : 1'b0;
      end else begin
        o_col[j] = (COL_W'(j) < w_csel) ? 1'b1 : 1'b0;
      end
    end
  end

endmodule

// File: rtl/dco_cbank_ctrl.sv
// Slew-limited capacitor-bank controller; all state updates on the falling clock edge.
// Optional sigma-delta dither of the applied code is enabled by DCO_CBANK_DITHER_EN.
module dco_cbank_ctrl
  import dco_cbank_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int ROW_W      = DEF_ROW_W,
  parameter int COL_W      = DEF_COL_W,
  parameter int RST_WORD   = 128,
  parameter int MAX_STEP   = 4,
  parameter int SETTLE_CYC = 2,
  parameter int FRAC_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  dco_cbank_ctrl_if.slave          bus,
`ifdef DCO_CBANK_DITHER_EN
  input  logic [FRAC_W-1:0]        frac_i,
`endif
  output logic [(1<<ROW_W)-1:0]    r_all_n,
  output logic [(1<<ROW_W)-1:0]    row,
  output logic [(1<<COL_W)-1:0]    col,
  output logic [ROW_W+COL_W-1:0]   code_o,
  output logic                     busy_o,
  output logic                     sat_o
);

  localparam int CW    = ROW_W + COL_W;
  localparam int NR    = 1 << ROW_W;
  localparam int NC    = 1 << COL_W;
  localparam int CNT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CW-1:0]    MAXC   = '1;
  localparam logic [CW-1:0]    RST_C  = CW'(RST_WORD);
  localparam logic [CW-1:0]    STEP_C = CW'(MAX_STEP);
  localparam logic [CNT_W-1:0] SET_C  = CNT_W'(SETTLE_CYC);

  state_e           r_state;
  logic [CW-1:0]    r_cur, r_tgt, r_code;
  logic [CNT_W-1:0] r_cnt;
  logic [NR-1:0]    r_all_n_q, r_row;
  logic [NC-1:0]    r_col;
  logic             r_rdy, r_busy, r_sat;

  state_e           w_state_nxt;
  logic [CW-1:0]    w_cur_nxt, w_tgt_nxt, w_app_nxt, w_dec_in;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CW-1:0]    w_word_clamped, w_dist, w_step, w_cur_step;
  logic             w_clamp, w_accept, w_up, w_sat;
  logic [NR-1:0]    w_dec_all_n, w_dec_row;
  logic [NC-1:0]    w_dec_col;

  generate
    if (WORD_W > CW) begin : g_clamp
      assign w_clamp        = |bus.word_i[WORD_W-1:CW];
      assign w_word_clamped = w_clamp ? MAXC : bus.word_i[CW-1:0];
    end else begin : g_noclamp
      assign w_clamp        = 1'b0;
      assign w_word_clamped = CW'(bus.word_i);
    end
  endgenerate

  assign w_accept   = bus.word_vld_i & (r_state == IDLE) & en;
  assign w_up       = (r_tgt > r_cur);
  assign w_dist     = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);
  assign w_step     = (w_dist > STEP_C) ? STEP_C : w_dist;
  assign w_cur_step = w_up ? (r_cur + w_step) : (r_cur - w_step);

  // Next-state, next-code and clamp-pulse computation.
  always_comb begin
    w_state_nxt = r_state;
    w_cur_nxt   = r_cur;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    w_sat       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_tgt_nxt = w_word_clamped;
          w_sat     = w_clamp;
          if (w_word_clamped != r_cur) begin
            w_state_nxt = SLEW;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SLEW: begin
        w_cur_nxt = w_cur_step;
        if (w_cur_step == r_tgt) begin
          if (SETTLE_CYC == 0) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SETTLE;
            w_cnt_nxt   = SET_C;
          end
        end else begin
          w_state_nxt = SLEW;
        end
      end
      SETTLE: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_state_nxt = SETTLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef DCO_CBANK_DITHER_EN
  logic [FRAC_W-1:0] r_acc;
  logic [FRAC_W:0]   w_acc_sum;
  logic              w_carry;
  logic [CW:0]       w_app_sum;

  assign w_acc_sum = {1'b0, r_acc} + {1'b0, frac_i};
  assign w_carry   = (r_state == IDLE) & ~w_accept & w_acc_sum[FRAC_W];
  assign w_app_sum = {1'b0, w_cur_nxt} + (CW+1)'(w_carry);
  assign w_app_nxt = w_app_sum[CW] ? MAXC : w_app_sum[CW-1:0];

  // First-order accumulator, only running while idle.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (en) begin
      if (w_accept) begin
        r_acc <= '0;
      end else if (r_state == IDLE) begin
        r_acc <= w_acc_sum[FRAC_W-1:0];
      end else begin
        r_acc <= r_acc;
      end
    end else begin
      r_acc <= r_acc;
    end
  end
`else
  assign w_app_nxt = w_cur_nxt;
`endif

  assign w_dec_in = rst ? RST_C : w_app_nxt;

  dco_cbank_decode #(.ROW_W(ROW_W), .COL_W(COL_W)) u_decode (
    .i_code    (w_dec_in),
    .o_r_all_n (w_dec_all_n),
    .o_row     (w_dec_row),
    .o_col     (w_dec_col)
  );

  // Control state and registered outputs, which track the code being loaded.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cur     <= RST_C;
      r_tgt     <= RST_C;
      r_cnt     <= '0;
      r_code    <= RST_C;
      r_all_n_q <= w_dec_all_n;
      r_row     <= w_dec_row;
      r_col     <= w_dec_col;
      r_rdy     <= 1'b1;
      r_busy    <= 1'b0;
      r_sat     <= 1'b0;
    end else if (en) begin
      r_state   <= w_state_nxt;
      r_cur     <= w_cur_nxt;
      r_tgt     <= w_tgt_nxt;
      r_cnt     <= w_cnt_nxt;
      r_code    <= w_app_nxt;
      r_all_n_q <= w_dec_all_n;
      r_row     <= w_dec_row;
      r_col     <= w_dec_col;
      r_rdy     <= (w_state_nxt == IDLE);
      r_busy    <= (w_state_nxt != IDLE);
      r_sat     <= w_sat;
    end else begin
      r_sat     <= 1'b0;
    end
  end

  assign bus.word_rdy_o = r_rdy;
  assign r_all_n        = r_all_n_q;
  assign row            = r_row;
  assign col            = r_col;
  assign code_o         = r_code;
  assign busy_o         = r_busy;
  assign sat_o          = r_sat;

endmodule

// File: tb/tb_dco_cbank_ctrl.sv
// Directed bench for dco_cbank_ctrl: default build plus a WORD_W=10 instance for clamping.
module tb_dco_cbank_ctrl;

  logic clk;
  logic rst;
  logic en;
  int   nvec;
  int   nerr;
  int   n;

  logic [15:0] r_all_n0, row0, r_all_n1, row1;
  logic [15:0] col0, col1;
  logic [7:0]  code0, code1;
  logic        busy0, busy1, sat0, sat1;

  dco_cbank_ctrl_if #(.WORD_W(8))  if0 ();
  dco_cbank_ctrl_if #(.WORD_W(10)) if1 ();

  dco_cbank_ctrl #(.WORD_W(8)) u0 (
    .clk(clk), .rst(rst), .en(en), .bus(if0.slave),
    .r_all_n(r_all_n0), .row(row0), .col(col0),
    .code_o(code0), .busy_o(busy0), .sat_o(sat0)
  );

  dco_cbank_ctrl #(.WORD_W(10)) u1 (
    .clk(clk), .rst(rst), .en(en), .bus(if1.slave),
    .r_all_n(r_all_n1), .row(row1), .col(col1),
    .code_o(code1), .busy_o(busy1), .sat_o(sat1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_code(input bit sel, input logic [7:0] want, output int edges);
    edges = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if ((sel ? code1 : code0) === want) begin
        edges = k;
        break;
      end
    end
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    en  = 1'b1;
    if0.word_i = 8'd0;  if0.word_vld_i = 1'b0;
    if1.word_i = 10'd0; if1.word_vld_i = 1'b0;
    tick();
    tick();
    chk("rst_r_all_n", 32'(r_all_n0), 32'hFF00);
    chk("rst_row", 32'(row0), 32'h0100);
    chk("rst_col", 32'(col0), 32'h0000);
    chk("rst_code", 32'(code0), 32'd128);
    chk("rst_rdy", 32'(if0.word_rdy_o), 32'd1);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_sat", 32'(sat0), 32'd0);
    chk("rst_code_w10", 32'(code1), 32'd128);
    rst = 1'b0;

    // 128 -> 133: two slew edges then two settle edges
    if0.word_i = 8'd133; if0.word_vld_i = 1'b1;
    tick();
    if0.word_vld_i = 1'b0;
    chk("acc133_code", 32'(code0), 32'd128);
    chk("acc133_rdy", 32'(if0.word_rdy_o), 32'd0);
    chk("acc133_busy", 32'(busy0), 32'd1);
    tick();
    chk("slew133_code1", 32'(code0), 32'd132);
    tick();
    chk("slew133_code2", 32'(code0), 32'd133);
    chk("slew133_col", 32'(col0), 32'h001F);
    chk("slew133_r_all_n", 32'(r_all_n0), 32'hFF00);
    chk("slew133_row", 32'(row0), 32'h0100);
    chk("slew133_rdy", 32'(if0.word_rdy_o), 32'd0);
    tick();
    chk("settle133_rdy", 32'(if0.word_rdy_o), 32'd0);
    chk("settle133_busy", 32'(busy0), 32'd1);
    tick();
    chk("idle133_rdy", 32'(if0.word_rdy_o), 32'd1);
    chk("idle133_busy", 32'(busy0), 32'd0);

    // 133 -> 147: odd row, serpentine columns from the top
    if0.word_i = 8'd147; if0.word_vld_i = 1'b1;
    tick();
    if0.word_vld_i = 1'b0;
    wait_code(1'b0, 8'd147, n);
    chk("slew147_edges", 32'(n), 32'd4);
    chk("fin147_r_all_n", 32'(r_all_n0), 32'hFE00);
    chk("fin147_row", 32'(row0), 32'h0200);
    chk("fin147_col", 32'(col0), 32'hE000);
    tick();
    tick();
    chk("idle147_rdy", 32'(if0.word_rdy_o), 32'd1);

    // back to 128, then full-scale excursions to 0 and 255
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_code", 32'(code0), 32'd128);
    if0.word_i = 8'd0; if0.word_vld_i = 1'b1;
    tick();
    if0.word_vld_i = 1'b0;
    wait_code(1'b0, 8'd0, n);
    chk("slew0_edges", 32'(n), 32'd32);
    chk("fin0_r_all_n", 32'(r_all_n0), 32'hFFFF);
    chk("fin0_row", 32'(row0), 32'h0001);
    chk("fin0_col", 32'(col0), 32'h0000);
    tick();
    tick();
    chk("idle0_rdy", 32'(if0.word_rdy_o), 32'd1);
    if0.word_i = 8'hFF; if0.word_vld_i = 1'b1;
    tick();
    if0.word_vld_i = 1'b0;
    chk("acc255_sat", 32'(sat0), 32'd0);
    wait_code(1'b0, 8'd255, n);
    chk("slew255_edges", 32'(n), 32'd64);
    chk("fin255_r_all_n", 32'(r_all_n0), 32'h8000);
    chk("fin255_row", 32'(row0), 32'h8000);
    chk("fin255_col", 32'(col0), 32'hFFFE);
    tick();
    tick();

    // wide-word instance: 0x3FF clamps to 255 with a single sat pulse
    if1.word_i = 10'h3FF; if1.word_vld_i = 1'b1;
    tick();
    if1.word_vld_i = 1'b0;
    chk("clamp_sat_hi", 32'(sat1), 32'd1);
    chk("clamp_code_acc", 32'(code1), 32'd128);
    tick();
    chk("clamp_sat_lo", 32'(sat1), 32'd0);
    chk("clamp_code1", 32'(code1), 32'd132);
    wait_code(1'b1, 8'd255, n);
    chk("clamp_edges", 32'(n), 32'd31);
    tick();
    chk("clamp_hold", 32'(code1), 32'd255);
    tick();

    // freeze mid-slew, then reset mid-slew
    if0.word_i = 8'd16; if0.word_vld_i = 1'b1;
    tick();
    if0.word_vld_i = 1'b0;
    tick();
    chk("frz_pre_code", 32'(code0), 32'd251);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("frz_code", 32'(code0), 32'd251);
      chk("frz_busy", 32'(busy0), 32'd1);
    end
    en = 1'b1;
    tick();
    chk("frz_resume_code", 32'(code0), 32'd247);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_code", 32'(code0), 32'd128);
    chk("midrst_rdy", 32'(if0.word_rdy_o), 32'd1);
    chk("midrst_busy", 32'(busy0), 32'd0);
    chk("midrst_r_all_n", 32'(r_all_n0), 32'hFF00);
    chk("midrst_row", 32'(row0), 32'h0100);
    chk("midrst_col", 32'(col0), 32'h0000);
    tick();
    chk("midrst_stay", 32'(code0), 32'd128);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dco_cbank_ctrl.md
Name: dco_cbank_ctrl

Overview:
- Slew-limited, handshaked capacitor-bank controller for the WSN DCO.
- Accepts a target tuning word and walks the applied code toward it in bounded steps.
- Decodes the applied code into zero-active row-all, one-hot row and serpentine column selects for a ROWS x COLS unit-capacitor array.
- Non-square arrays, input saturation and a settle guard are supported, so the ADPLL loop never causes large glitching jumps in bank capacitance.

Parameters:
- WORD_W, 8: width of word_i; must be >= ROW_W+COL_W.
- ROW_W, 4: log2 of row count (NROWS = 2^ROW_W).
- COL_W, 4: log2 of column count (NCOLS = 2^COL_W).
- RST_WORD, 128: applied code after reset.
- MAX_STEP, 4: maximum change of the applied code per clock.
- SETTLE_CYC, 2: idle-guard cycles after the target is reached (0 allowed).
- FRAC_W, 4: dither fraction width (used only with the optional feature).

Ports:
- clk  in  1  clock; all registers update on negedge clk.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  clock enable; 0 freezes all state and outputs.
- word_i  in  WORD_W  target tuning word.
- word_vld_i  in  1  target valid.
- word_rdy_o  out  1  ready to accept a target.
- frac_i  in  FRAC_W  dither fraction (present only with DCO_CBANK_DITHER_EN).
- r_all_n  out  NROWS  zero-active "row fully on" thermometer.
- row  out  NROWS  one-hot partially-filled row.
- col  out  NCOLS  column select for the partial row.
- code_o  out  ROW_W+COL_W  current applied code.
- busy_o  out  1  high in SLEW or SETTLE.
- sat_o  out  1  one-cycle pulse when an accepted word was clamped.

Behaviour:
- MAX_CODE = 2^(ROW_W+COL_W)-1. Split the applied code A into rsel = A>>COL_W and csel = A[COL_W-1:0].
- Row decode:
  - r_all_n[i] = 0 for i<rsel, else 1.
  - row[i] = (i==rsel).
- Column decode (serpentine by row parity):
  - rsel even: col[j] = 1 for j<csel.
  - rsel odd: col[j] = 1 for j >= NCOLS-csel.
- All outputs are registered. They are the decode of the cur register as it is updated on the same edge.
- Reset:
  - cur = RST_WORD, target = RST_WORD, state = IDLE.
  - Outputs decode RST_WORD; with defaults: r_all_n=0xFF00, row=0x0100, col=0x0000.
  - word_rdy_o=1, busy_o=0, sat_o=0, settle counter=0.
- rst has priority over en. Reset mid-slew returns everything to reset values on the next edge.
- word_rdy_o = (state==IDLE).
- Accept:
  - Occurs when word_vld_i & word_rdy_o & en.
  - target <= min(word_i, MAX_CODE); sat_o <= 1 for one cycle if word_i > MAX_CODE.
  - If the clamped word != cur, go to SLEW; otherwise stay IDLE.
  - cur is unchanged on the accept edge.
- State SLEW, each enabled edge:
  - cur moves toward target by min(|target-cur|, MAX_STEP).
  - If the new cur == target: go to SETTLE with counter=SETTLE_CYC, or go directly to IDLE when SETTLE_CYC=0.
- State SETTLE: counter decrements each enabled edge; go to IDLE when it reaches 1→0. word_rdy_o therefore rises SETTLE_CYC edges after the edge where cur reached target.
- en=0: state, cur, counter and outputs hold. sat_o is forced to 0.
- Slew duration = ceil(|target-cur|/MAX_STEP) edges.

Optional Feature:
- DCO_CBANK_DITHER_EN defined:
  - frac_i port exists.
  - In IDLE, a FRAC_W-bit first-order sigma-delta accumulator adds frac_i each enabled edge; its carry is added to cur.
  - Applied code = min(cur+carry, MAX_CODE), and outputs/code_o decode the applied code.
  - The accumulator clears on reset and on every accept.
  - Outside IDLE, carry = 0.
- Not defined: no frac_i port, no accumulator; applied code = cur.

Decomposition:
- Package dco_cbank_pkg:
  - State enum {IDLE, SLEW, SETTLE}.
  - Helper localparams NROWS, NCOLS, MAX_CODE, CODE_W = ROW_W+COL_W.
- Sub-module dco_cbank_decode: purely combinational code → r_all_n/row/col serpentine decoder, parametrised by ROW_W and COL_W.

Test Plan:
- Reset with defaults → r_all_n=0xFF00, row=0x0100, col=0x0000, code_o=128, word_rdy_o=1, busy_o=0.
- From 128, accept word 133 → code_o reads 128 on the accept edge, then 132, then 133 with col=0x001F. word_rdy_o stays 0 for the two SETTLE edges, then returns to 1.
- Accept 147 (0x93) → final r_all_n=0xFE00, row=0x0200, col=0xE000 (odd row, csel=3 filled from MSB).
- Accept 0x00 from 128 → 32 SLEW edges, final r_all_n=0xFFFF, row=0x0001, col=0. Then accept 0xFF → final r_all_n=0x8000, row=0x8000, col=0xFFFE.
- WORD_W=10 build, accept 0x3FF → target clamps to 255, sat_o high for exactly one cycle.
- Mid-slew: drop en for 3 cycles → code_o frozen. Then assert rst during SLEW → next edge code_o=128, state IDLE, word_rdy_o=1.
